ascii_dec_to_binary: RTL
========================

// Module: ascii_dec_to_binary
// PURPOSE
//  Parses a stream of ASCII decimal characters from the UART receive path into a W-bit unsigned binary value.
//  It is the input-side counterpart of the binary-to-7SEG display path: operators type "0".."255" plus CR/LF,
//  and the block emits the binary number with a one-cycle valid pulse.
//  Malformed or out-of-range entries are flagged and discarded. Backspace edits are supported.
// PARAMETERS
//  W           8   result width; accepted range 0 .. 2**W-1
//  MAX_DIGITS  3   max digits per entry, leading zeros included; must be >= 1 and <= 7
// PORTS
//  clk            in   1      single clock; all logic is rising-edge
//  rst_n          in   1      synchronous, active-low reset
//  rx_data        in   8      received ASCII byte
//  rx_valid       in   1      rx_data is valid this cycle; one byte per cycle, no backpressure
//  value          out  W      last successfully parsed number; holds between updates
//  value_valid    out  1      1-cycle pulse: value was updated this cycle
//  err_overflow   out  1      1-cycle pulse: entry exceeded 2**W-1 or MAX_DIGITS
//  err_char       out  1      1-cycle pulse: illegal character received
//  busy           out  1      1 while an entry is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; acc=0; cnt=0; value=0; all pulses=0; busy=0.
//   Reset wins over any rx_valid in the same cycle. Reset mid-entry silently drops the entry.
//  Character classes (only when rx_valid=1; rx_valid=0 means no state change and pulses low):
//   DIGIT 0x30-0x39; TERM 0x0D or 0x0A; BS 0x08 or 0x7F; OTHER = everything else.
//  States: IDLE, ACCUM, DISCARD. All outputs are registered. Response appears the cycle after the byte.
//   IDLE:    DIGIT -> acc=d, cnt=1, ACCUM | TERM, BS -> ignored, stay
//            OTHER -> err_char, DISCARD
//   ACCUM:   DIGIT -> nxt = acc*10+d, computed at width W+4 (no truncation before compare)
//              if cnt==MAX_DIGITS or nxt > 2**W-1 -> err_overflow, DISCARD; else acc=nxt[W-1:0], cnt++
//            TERM  -> value=acc, value_valid, acc=0, cnt=0, IDLE
//            BS    -> acc=acc/10, cnt--; if cnt becomes 0 -> IDLE
//            OTHER -> err_char, acc=0, cnt=0, DISCARD
//   DISCARD: TERM -> acc=0, cnt=0, IDLE with no value_valid. All other bytes are ignored and raise no further pulses.
//  Boundary conditions:
//   - CR LF pair: the first TERM completes the entry; the second arrives in IDLE and is ignored.
//     Exactly one value_valid is produced.
//   - Exactly 2**W-1 is accepted. 2**W-1+1 raises overflow.
//   - Leading zeros count as digits; "000" is legal and yields 0.
//   - Overflow has priority over the digit-count check only in naming: both raise err_overflow. At most one pulse per byte.
//   - value_valid, err_overflow and err_char are mutually exclusive in any cycle.
//   - value is unchanged by errors, BS or reset-free idle bytes.
// STRUCTURE
//  Shared package uart_ascii_pkg holds:
//   - ASCII localparams: ASC_0, ASC_9, ASC_CR, ASC_LF, ASC_BS, ASC_DEL
//   - state encoding: IDLE=2'd0, ACCUM=2'd1, DISCARD=2'd2
//  Sub-module dec_mac10: combinational nxt = {acc,3'b0}+{acc,1'b0}+d, width W+4 (shift-add, no multiplier).
//  Everything else is one FSM plus datapath registers in this module. acc/10 uses the synthesized divider, matching the display path.
// TESTING
//  T1 reset: hold rst_n=0 while sending "12\r" -> value=0, no pulses, busy=0. Release, send "7\r" -> value=7, one value_valid.
//  T2 bounds (W=8): send "255\r" -> value=255 with one valid. Then "256\r" -> err_overflow on '6', no valid, value stays 255.
//  T3 digit limit: "0042\r" -> err_overflow on the 4th byte, DISCARD. A following "42\r\n" -> value=42, exactly one valid.
//  T4 edits: "19<BS>8\r" -> value=18. "5<BS>\r" -> no pulse, busy returns to 0 after BS.
//  T5 bad char: "1a2\r" -> err_char on 'a', no valid. A back-to-back next entry "3\r" -> value=3.
//  T6 gaps: the same strings sent with random rx_valid idle cycles give identical results. Pulse exclusivity is asserted on every cycle.

Source files
------------

// File: rtl/uart_ascii_pkg.sv
// Shared ASCII constants, FSM encoding and character classifier for the UART
// ASCII front end.
package uart_ascii_pkg;

  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_9   = 8'h39;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_DEL = 8'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CC_DIGIT = 2'd0,
    CC_TERM  = 2'd1,
    CC_BS    = 2'd2,
    CC_OTHER = 2'd3
  } char_class_t;

  // Decoded byte: its class and, for digits, the numeric value.
  typedef struct packed {
    char_class_t cls;
    logic [3:0]  digit;
  } char_info_t;

  // Sorts one received byte into DIGIT / TERM / BS / OTHER.
  function automatic char_info_t classify(input logic [7:0] b);
    char_info_t r;
    r.cls   = CC_OTHER;
    r.digit = 4'd0;
    if ((b >= ASC_0) && (b <= ASC_9)) begin
      r.cls   = CC_DIGIT;
      r.digit = 4'(b - ASC_0);
    end else if ((b == ASC_CR) || (b == ASC_LF)) begin
      r.cls = CC_TERM;
    end else if ((b == ASC_BS) || (b == ASC_DEL)) begin
      r.cls = CC_BS;
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_mac10.sv
// Decimal shift-add step: nxt_c = acc*10 + d, produced at W+4 bits so the
// result never truncates before the range compare.
//   acc    in  W    current accumulator
//   d      in  4    new decimal digit (0..9)
//   nxt_c  out W+4  acc*10 + d (combinational)
module dec_mac10 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   d,
  output logic [W+3:0] nxt_c
);

  logic [W+3:0] x8_c;
  logic [W+3:0] x2_c;
  logic [W+3:0] dx_c;

  // acc*8 + acc*2 + d
  assign x8_c  = {1'b0, acc, 3'b000};
  assign x2_c  = {3'b000, acc, 1'b0};
  assign dx_c  = (W+4)'(d);
  assign nxt_c = x8_c + x2_c + dx_c;

endmodule

// File: rtl/ascii_dec_to_binary.sv
// Parses ASCII decimal entries ("0".."2**W-1" terminated by CR or LF) into a
// W-bit binary value. Malformed or out-of-range entries are flagged and
// dropped; BS/DEL removes the last digit.
//   clk           in   1  rising-edge clock
//   rst_n         in   1  synchronous active-low reset
//   rx_data       in   8  received ASCII byte
//   rx_valid      in   1  rx_data valid this cycle
//   value         out  W  last accepted number, held between updates
//   value_valid   out  1  one-cycle pulse when value updates
//   err_overflow  out  1  one-cycle pulse: entry too large or too many digits
//   err_char      out  1  one-cycle pulse: illegal character
//   busy          out  1  an entry is in progress
module ascii_dec_to_binary
  import uart_ascii_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [W-1:0] value,
  output logic         value_valid,
  output logic         err_overflow,
  output logic         err_char,
  output logic         busy
);

  // MAX_DIGITS is at most 7, so three bits always hold the digit count.
  localparam int unsigned CW           = 3;
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [W+3:0]  MAX_VAL    = {4'b0000, {W{1'b1}}};
  localparam logic [W-1:0]  TEN        = W'(10);

  state_t        state;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  char_info_t    ci_c;
  logic [W+3:0]  nxt_c;
  logic          ovf_c;
  logic [W-1:0]  acc_div10_c;

  // Byte decode.
  assign ci_c = classify(rx_data);

  // Candidate accumulator for a new digit.
  dec_mac10 #(.W(W)) u_mac (
    .acc   (acc),
    .d     (ci_c.digit),
    .nxt_c (nxt_c)
  );

  // Digit-count and value-range checks both map onto err_overflow.
  assign ovf_c = (cnt == CNT_MAX) || (nxt_c > MAX_VAL);

  // Backspace drops the least significant decimal digit.
  assign acc_div10_c = acc / TEN;

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      err_overflow <= 1'b0;
      err_char     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      value_valid  <= 1'b0;
      err_overflow <= 1'b0;
      err_char     <= 1'b0;
      if (rx_valid) begin
        unique case (state)
          IDLE: begin
            unique case (ci_c.cls)
              CC_DIGIT: begin
                acc   <= W'(ci_c.digit);
                cnt   <= CNT_ONE;
                state <= ACCUM;
                busy  <= 1'b1;
              end
              CC_OTHER: begin
                err_char <= 1'b1;
                state    <= DISCARD;
                busy     <= 1'b1;
              end
              default: ; // stray TERM/BS between entries
            endcase
          end

          ACCUM: begin
            unique case (ci_c.cls)
              CC_DIGIT: begin
                if (ovf_c) begin
                  err_overflow <= 1'b1;
                  acc          <= '0;
                  cnt          <= '0;
                  state        <= DISCARD;
                end else begin
                  acc <= nxt_c[W-1:0];
                  cnt <= cnt + CNT_ONE;
                end
              end
              CC_TERM: begin
                value       <= acc;
                value_valid <= 1'b1;
                acc         <= '0;
                cnt         <= '0;
                state       <= IDLE;
                busy        <= 1'b0;
              end
              CC_BS: begin
                acc <= acc_div10_c;
                cnt <= cnt - CNT_ONE;
                // Erasing the only digit abandons the entry.
                if (cnt == CNT_ONE) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
              default: begin
                err_char <= 1'b1;
                acc      <= '0;
                cnt      <= '0;
                state    <= DISCARD;
              end
            endcase
          end

          DISCARD: begin
            // Swallow the rest of a bad entry up to its terminator.
            if (ci_c.cls == CC_TERM) begin
              acc   <= '0;
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
